pipe_ctrl_unit: RTL and testbench

- Decode-stage control unit for the pipelined 16-bit WISC core.
- Decodes the ID instruction into a control bundle and registers it into the ID/EX boundary.
- Detects load-use hazards and generates stalls, applies branch flushes, and runs a halt-drain state machine so the core stops only after older instructions retire.
- Sits between the IF/ID pipeline register and the ID/EX pipeline register.

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 89 ++++++++
 rtl/pipe_ctrl_unit.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the WISC decode-stage control unit: control bundle, opcodes, halt FSM states.
package ctrl_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned REG_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD    = 4'h0;
    localparam logic [OPC_W-1:0] OPC_SUB    = 4'h1;
    localparam logic [OPC_W-1:0] OPC_XOR    = 4'h2;
    localparam logic [OPC_W-1:0] OPC_RED    = 4'h3;
    localparam logic [OPC_W-1:0] OPC_SLL    = 4'h4;
    localparam logic [OPC_W-1:0] OPC_SRA    = 4'h5;
    localparam logic [OPC_W-1:0] OPC_ROR    = 4'h6;
    localparam logic [OPC_W-1:0] OPC_PADDSB = 4'h7;
    localparam logic [OPC_W-1:0] OPC_LW     = 4'h8;
    localparam logic [OPC_W-1:0] OPC_SW     = 4'h9;
    localparam logic [OPC_W-1:0] OPC_LLB    = 4'hA;
    localparam logic [OPC_W-1:0] OPC_LHB    = 4'hB;
    localparam logic [OPC_W-1:0] OPC_B      = 4'hC;
    localparam logic [OPC_W-1:0] OPC_BR     = 4'hD;
    localparam logic [OPC_W-1:0] OPC_PCS    = 4'hE;
    localparam logic [OPC_W-1:0] OPC_HLT    = 4'hF;

    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] opc;
        logic [REG_W-1:0] dst;
        logic             reg_dst;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic             lower;
        logic             higher;
        logic             ben;
        logic             br;
        logic             pcs;
        logic             halt;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: control bundle plus the register sources the instruction reads.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [15:0]      instr,
    output ctrl_t            ctrl,
    output logic [REG_W-1:0] src_a,
    output logic [REG_W-1:0] src_b,
    output logic             src_a_used,
    output logic             src_b_used
);

    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;

    assign opc = instr[15:12];
    assign rd  = instr[11:8];
    assign rs  = instr[7:4];
    assign rt  = instr[3:0];

    always_comb begin
        ctrl       = CTRL_BUBBLE;
        ctrl.valid = 1'b1;
        ctrl.opc   = opc;
        ctrl.dst   = rd;
        src_a      = rs;
        src_b      = rt;
        src_a_used = 1'b0;
        src_b_used = 1'b0;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_XOR, OPC_RED, OPC_PADDSB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                src_a_used     = 1'b1;
                src_b_used     = 1'b1;
            end
            OPC_SLL, OPC_SRA, OPC_ROR: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                src_a_used     = 1'b1;
            end
            OPC_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                src_a_used      = 1'b1;
            end
            OPC_SW: begin
                // Store data comes from rd, so it is a second source.
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                src_a_used     = 1'b1;
                src_b          = rd;
                src_b_used     = 1'b1;
            end
            OPC_LLB, OPC_LHB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.lower     = (opc == OPC_LLB);
                ctrl.higher    = (opc == OPC_LHB);
                src_a          = rd;
                src_a_used     = 1'b1;
            end
            OPC_B: begin
                ctrl.ben = 1'b1;
            end
            OPC_BR: begin
                ctrl.ben   = 1'b1;
                ctrl.br    = 1'b1;
                src_a_used = 1'b1;
            end
            OPC_PCS: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.pcs       = 1'b1;
            end
            OPC_HLT: begin
                ctrl.halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control: ID/EX bundle register, load-use stall, branch flush and halt drain FSM.
// Optional saturating stall/flush performance counters are built when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    input  logic             flush,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output ctrl_t            ctrl_q,
    output logic             stall,
    output logic             pc_hold,
    output logic             halt_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DCNT_W = 4;

    ctrl_t             dec_ctrl;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic              src_a_used;
    logic              src_b_used;

    state_e            state_q, state_d;
    logic [DCNT_W-1:0] drain_q, drain_d;
    ctrl_t             ctrl_d;
    logic              pc_hold_q, pc_hold_d;
    logic              halt_done_q, halt_done_d;

    ctrl_decode u_decode (
        .instr      (instr),
        .ctrl       (dec_ctrl),
        .src_a      (src_a),
        .src_b      (src_b),
        .src_a_used (src_a_used),
        .src_b_used (src_b_used)
    );

    // Load-use hazard; register 0 is hardwired and never a dependency.
    assign stall = (state_q == ST_RUN) && instr_valid && !flush && ex_memread
                   && (ex_rd != '0)
                   && ((src_a_used && (src_a == ex_rd)) || (src_b_used && (src_b == ex_rd)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        ctrl_d      = CTRL_BUBBLE;
        case (state_q)
            ST_RUN: begin
                if (!flush && !stall && instr_valid) begin
                    ctrl_d = dec_ctrl;
                    if (dec_ctrl.halt) begin
                        state_d = ST_DRAIN;
                        drain_d = DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DCNT_W'(1);
                end
            end
            ST_HALTED: ;
            default:   state_d = ST_RUN;
        endcase
        pc_hold_d   = (state_d != ST_RUN);
        halt_done_d = halt_done_q | (state_q == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            pc_hold_q   <= 1'b0;
            halt_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ctrl_q      <= ctrl_d;
            pc_hold_q   <= pc_hold_d;
            halt_done_q <= halt_done_d;
        end
    end

    assign pc_hold   = pc_hold_q;
    assign halt_done = halt_done_q;

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; flushes only count while running.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (state_q == ST_RUN) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized self-checking bench for pipe_ctrl_unit against a behavioural reference model.
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    localparam int unsigned DRAIN   = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_valid = 1'b0;
    logic [15:0]      instr = '0;
    logic             flush = 1'b0;
    logic             ex_memread = 1'b0;
    logic [3:0]       ex_rd = '0;
    ctrl_t            ctrl_q;
    logic             stall;
    logic             pc_hold;
    logic             halt_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .flush       (flush),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .ctrl_q      (ctrl_q),
        .stall       (stall),
        .pc_hold     (pc_hold),
        .halt_done   (halt_done),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: edges since HLT was issued (-1 = running), last bundle, counters.
    int    m_hlt_edges = -1;
    ctrl_t m_ctrl = '0;
    int    m_stall_cnt = 0;
    int    m_flush_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ctrl_t ref_decode(input logic [15:0] ins);
        ctrl_t      c;
        logic [3:0] op;
        op      = ins[15:12];
        c       = '0;
        c.valid = 1'b1;
        c.opc   = op;
        c.dst   = ins[11:8];
        if (op <= 4'h3 || op == 4'h7) begin
            c.reg_dst = 1'b1; c.reg_write = 1'b1;
        end else if (op <= 4'h6) begin
            c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
        end else if (op == 4'h8) begin
            c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
        end else if (op == 4'h9) begin
            c.alu_src = 1'b1; c.mem_write = 1'b1;
        end else if (op == 4'hA || op == 4'hB) begin
            c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
            c.lower = (op == 4'hA); c.higher = (op == 4'hB);
        end else if (op == 4'hC) begin
            c.ben = 1'b1;
        end else if (op == 4'hD) begin
            c.ben = 1'b1; c.br = 1'b1;
        end else if (op == 4'hE) begin
            c.reg_dst = 1'b1; c.reg_write = 1'b1; c.pcs = 1'b1;
        end else begin
            c.halt = 1'b1;
        end
        return c;
    endfunction

    function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
        logic [3:0] srcs[$];
        logic [3:0] op;
        op = ins[15:12];
        if (op <= 4'h3 || op == 4'h7) begin
            srcs.push_back(ins[7:4]); srcs.push_back(ins[3:0]);
        end else if (op <= 4'h6 || op == 4'h8 || op == 4'hD) begin
            srcs.push_back(ins[7:4]);
        end else if (op == 4'h9) begin
            srcs.push_back(ins[7:4]); srcs.push_back(ins[11:8]);
        end else if (op == 4'hA || op == 4'hB) begin
            srcs.push_back(ins[11:8]);
        end
        foreach (srcs[i]) begin
            if (srcs[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        check_val("ctrl_q",    32'(ctrl_q),    32'(m_ctrl));
        check_val("pc_hold",   32'(pc_hold),   32'(m_hlt_edges >= 0));
        check_val("halt_done", 32'(halt_done), 32'(m_hlt_edges >= int'(DRAIN + 1)));
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is observed before any edge.
    task automatic do_reset();
        m_hlt_edges = -1;
        m_ctrl      = '0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        rst_n = 1'b0;
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic fl,
                        input logic mr, input logic [3:0] rd);
        bit run;
        bit exp_stall;
        instr_valid = v;
        instr       = ins;
        flush       = fl;
        ex_memread  = mr;
        ex_rd       = rd;
        #1;
        run       = (m_hlt_edges < 0);
        exp_stall = run && v && !fl && mr && (rd != 4'd0) && reads_reg(ins, rd);
        check_val("stall", 32'(stall), 32'(exp_stall));
        if (!run) begin
            m_ctrl = '0;
            m_hlt_edges++;
        end else if (fl || exp_stall || !v) begin
            m_ctrl = '0;
        end else begin
            m_ctrl = ref_decode(ins);
            if (ins[15:12] == 4'hF) m_hlt_edges = 0;
        end
        if (PERF_EN) begin
            if (exp_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (fl && run && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_step(input bit allow_hlt);
        logic [3:0]  op;
        logic [15:0] ins;
        op = 4'($urandom_range(0, 15));
        if (!allow_hlt && op == 4'hF) op = 4'h0;
        ins = {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
        if ($urandom_range(0, 3) == 0) ins[11:0] = 12'($urandom);
        step(($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 5), 4'($urandom_range(0, 3)));
    endtask

    initial begin
        #1;
        do_reset();

        // Basic decode, load-use stall, r0 exemption, flush over hazard.
        step(1'b1, 16'h0123, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'h1320, 1'b0, 1'b1, 4'd2);
        step(1'b1, 16'h1320, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'h1320, 1'b0, 1'b1, 4'd0);
        step(1'b1, 16'h9512, 1'b0, 1'b1, 4'd5);
        step(1'b1, 16'hA700, 1'b0, 1'b1, 4'd7);
        do_reset();
        step(1'b1, 16'h1320, 1'b1, 1'b1, 4'd2);
        step(1'b0, 16'h0123, 1'b0, 1'b0, 4'd0);

        // Counter saturation under a held hazard.
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            step(1'b1, 16'h1320, 1'b0, 1'b1, 4'd2);
        end

        do_reset();
        for (int i = 0; i < 400; i++) rand_step(1'b0);

        // Halt drain: later instructions (even flushed ones) become bubbles.
        do_reset();
        step(1'b1, 16'hF000, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0123, (i == 1), 1'b1, 4'd2);

        // Reset while the drain counter is at 1, then normal decode resumes.
        do_reset();
        step(1'b1, 16'hF000, 1'b0, 1'b0, 4'd0);
        step(1'b1, 16'h0123, 1'b0, 1'b0, 4'd0);
        do_reset();
        step(1'b1, 16'h0123, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 600; i++) begin
            rand_step(1'b1);
            if (m_hlt_edges > int'(DRAIN + 4)) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
